// File: rtl/status_write_ctrl_if.sv
// Handshake and data bundle between the ALU/decoder control logic and the
// status-register write controller.
interface status_write_ctrl_if #(
    parameter int NumStatusBits = 6
);
    logic                     alu_req;
    logic                     alu_gnt;
    logic                     dec_req;
    logic [NumStatusBits-1:0] dec_status;
    logic                     dec_gnt;
    logic                     save_req;
    logic                     restore_req;
    logic [NumStatusBits-1:0] status_q;
    logic                     stat_wr_en;
    logic                     stat_sel_alu;
    logic [NumStatusBits-1:0] stat_dec_data;
    logic                     busy;
    logic                     stack_empty;
    logic                     stack_full;
    logic                     stack_err;

    modport master (
        output alu_req, dec_req, dec_status, save_req, restore_req, status_q,
        input  alu_gnt, dec_gnt, stat_wr_en, stat_sel_alu, stat_dec_data,
               busy, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  alu_req, dec_req, dec_status, save_req, restore_req, status_q,
        output alu_gnt, dec_gnt, stat_wr_en, stat_sel_alu, stat_dec_data,
               busy, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/status_write_ctrl.sv
// Status-register write arbiter (ALU vs decoder) with a shadow save/restore stack.
// Define STAT_CTRL_STACK_ERR_EN to build the sticky overflow/underflow flag.
module status_write_ctrl #(
    parameter int NumStatusBits = 6,
    parameter int StackDepth    = 4,
    parameter int MaxAluStreak  = 3
) (
    input logic                clk,
    input logic                res,
    status_write_ctrl_if.slave bus
);
    localparam int PtrW    = $clog2(StackDepth) + 1;
    localparam int StreakW = $clog2(MaxAluStreak + 1);

    typedef enum logic [1:0] {IDLE, RST_RD, RST_WR} state_e;

    state_e                   state_q, state_d;
    logic [PtrW-1:0]          ptr_q, ptr_d;
    logic [StreakW-1:0]       streak_q, streak_d;
    logic [NumStatusBits-1:0] stack_q [StackDepth];
    logic                     push;
    logic                     ptrEmpty, ptrFull, restoreTaken, gntPending;

    logic                     aluGnt_q, aluGnt_d;
    logic                     decGnt_q, decGnt_d;
    logic                     wrEn_q, wrEn_d;
    logic                     selAlu_q, selAlu_d;
    logic [NumStatusBits-1:0] decData_q, decData_d;
    logic                     busy_q, busy_d;
    logic                     empty_q, full_q;

    assign ptrEmpty     = (ptr_q == '0);
    assign ptrFull      = (ptr_q == PtrW'(StackDepth));
    assign restoreTaken = bus.restore_req && !ptrEmpty;
    // A grant pulse occupies the following edge so the requester can drop its req.
    assign gntPending   = aluGnt_q || decGnt_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        streak_d  = streak_q;
        push      = 1'b0;
        aluGnt_d  = 1'b0;
        decGnt_d  = 1'b0;
        wrEn_d    = 1'b0;
        selAlu_d  = 1'b0;
        decData_d = decData_q;
        busy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (restoreTaken) begin
                    ptr_d   = ptr_q - PtrW'(1);
                    state_d = RST_RD;
                    busy_d  = 1'b1;
                end else if (bus.save_req && !bus.restore_req && !ptrFull) begin
                    push  = 1'b1;
                    ptr_d = ptr_q + PtrW'(1);
                end

                if (!restoreTaken && !gntPending) begin
                    if (bus.dec_req && streak_q == StreakW'(MaxAluStreak)) begin
                        decGnt_d  = 1'b1;
                        decData_d = bus.dec_status;
                    end else if (bus.alu_req) begin
                        aluGnt_d = 1'b1;
                    end else if (bus.dec_req) begin
                        decGnt_d  = 1'b1;
                        decData_d = bus.dec_status;
                    end
                end
                wrEn_d   = aluGnt_d || decGnt_d;
                selAlu_d = aluGnt_d;
            end
            RST_RD: begin
                decData_d = stack_q[ptr_q[PtrW-2:0]];
                state_d   = RST_WR;
                wrEn_d    = 1'b1;
                busy_d    = 1'b1;
            end
            RST_WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!bus.dec_req || decGnt_d) begin
            streak_d = '0;
        end else if (aluGnt_d && streak_q != StreakW'(MaxAluStreak)) begin
            streak_d = streak_q + StreakW'(1);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            streak_q  <= '0;
            aluGnt_q  <= 1'b0;
            decGnt_q  <= 1'b0;
            wrEn_q    <= 1'b0;
            selAlu_q  <= 1'b0;
            decData_q <= '0;
            busy_q    <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            streak_q  <= streak_d;
            aluGnt_q  <= aluGnt_d;
            decGnt_q  <= decGnt_d;
            wrEn_q    <= wrEn_d;
            selAlu_q  <= selAlu_d;
            decData_q <= decData_d;
            busy_q    <= busy_d;
            empty_q   <= (ptr_d == '0);
            full_q    <= (ptr_d == PtrW'(StackDepth));
        end
    end

    // Stack storage needs no reset: entries are only read below the pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[ptr_q[PtrW-2:0]] <= bus.status_q;
        end
    end

`ifdef STAT_CTRL_STACK_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE &&
            ((bus.restore_req && ptrEmpty) ||
             (bus.save_req && !bus.restore_req && ptrFull))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.alu_gnt       = aluGnt_q;
    assign bus.dec_gnt       = decGnt_q;
    assign bus.stat_wr_en    = wrEn_q;
    assign bus.stat_sel_alu  = selAlu_q;
    assign bus.stat_dec_data = decData_q;
    assign bus.busy          = busy_q;
    assign bus.stack_empty   = empty_q;
    assign bus.stack_full    = full_q;
endmodule
